// File: rtl/joystick_conditioner.sv
// joystick_conditioner: synchronizes, debounces and resolves two active-low
// Atari-style joystick ports into active-high 5-bit vectors with a change strobe.
// Pin order on every 5-bit vector: 0=fire 1=left 2=right 3=down 4=up.
// Optional autofire is compiled in when the macro JOY_AUTOFIRE_EN is defined.
module joystick_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int TICK_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int AUTOFIRE_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:4] joy1_raw_n,
    input  logic [0:4] joy2_raw_n,
    input  logic [0:1] autofire_en,
    output logic [0:4] joy1,
    output logic [0:4] joy2,
    output logic       joy_changed
);

    localparam int NPINS = 10;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW    = $clog2(DEBOUNCE_TICKS) + 1;

    logic [0:9]             raw_n;
    logic [SYNC_STAGES-1:0] sync_q [NPINS];
    logic [0:9]             s;
    logic [PW-1:0]          pre_cnt;
    logic                   tick;
    logic [0:9]             d;
    logic [CW-1:0]          cnt [NPINS];
    logic [0:4]             res1;
    logic [0:4]             res2;
    logic [0:4]             joy1_prev;
    logic [0:4]             joy2_prev;

    assign raw_n = {joy1_raw_n, joy2_raw_n};

    // Shift each raw pin through its synchronizer chain; reset presets to the idle (high) level.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPINS; i++) begin
            if (reset) begin
                sync_q[i] <= '1;
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_n[i]};
            end
        end
    end

    // Take the last synchronizer stage and flip it to active-high.
    always_comb begin
        s = '0;
        for (int i = 0; i < NPINS; i++) begin
            s[i] = ~sync_q[i][SYNC_STAGES-1];
        end
    end

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    // Free-running prescaler producing one debounce tick every TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Per-pin debounce: a new level is accepted only after DEBOUNCE_TICKS disagreeing ticks in a row.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPINS; i++) begin
            if (reset) begin
                d[i]   <= 1'b0;
                cnt[i] <= '0;
            end else if (tick) begin
                if (s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef JOY_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_TICKS) + 1;

    logic [0:1]    phase;
    logic [AW-1:0] af_cnt [2];

    // Autofire phase per port; held clear unless fire is debounced-pressed and autofire is requested.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset || !(d[p*5] && autofire_en[p])) begin
                phase[p]  <= 1'b0;
                af_cnt[p] <= '0;
            end else if (tick) begin
                if (af_cnt[p] == AW'(AUTOFIRE_TICKS - 1)) begin
                    phase[p]  <= ~phase[p];
                    af_cnt[p] <= '0;
                end else begin
                    af_cnt[p] <= af_cnt[p] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_autofire;
    assign unused_autofire = ^autofire_en;
`endif

    // Cancel opposing directions on each port and apply autofire gating to fire.
    always_comb begin
        res1 = d[0:4];
        res2 = d[5:9];
        if (d[1] && d[2]) begin
            res1[1] = 1'b0;
            res1[2] = 1'b0;
        end
        if (d[3] && d[4]) begin
            res1[3] = 1'b0;
            res1[4] = 1'b0;
        end
        if (d[6] && d[7]) begin
            res2[1] = 1'b0;
            res2[2] = 1'b0;
        end
        if (d[8] && d[9]) begin
            res2[3] = 1'b0;
            res2[4] = 1'b0;
        end
`ifdef JOY_AUTOFIRE_EN
        res1[0] = d[0] & ~phase[0];
        res2[0] = d[5] & ~phase[1];
`endif
    end

    // Register the resolved outputs and strobe once in the cycle after either port changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            joy1        <= '0;
            joy2        <= '0;
            joy1_prev   <= '0;
            joy2_prev   <= '0;
            joy_changed <= 1'b0;
        end else begin
            joy1        <= res1;
            joy2        <= res2;
            joy1_prev   <= joy1;
            joy2_prev   <= joy2;
            joy_changed <= (joy1 != joy1_prev) || (joy2 != joy2_prev);
        end
    end

endmodule

// File: tb/tb_joystick_conditioner.sv
// Testbench for joystick_conditioner with small prescale/debounce values.
// Expected output vectors are queued when stimulus is applied and popped on each joy_changed pulse.
module tb_joystick_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:4] joy1_raw_n = 5'b11111;
    logic [0:4] joy2_raw_n = 5'b11111;
    logic [0:1] autofire_en = 2'b00;
    logic [0:4] joy1;
    logic [0:4] joy2;
    logic       joy_changed;

    int checks = 0;
    int fails = 0;
    int pulses = 0;
    logic [0:9] exp_q [$];

    joystick_conditioner #(
        .SYNC_STAGES(2),
        .TICK_DIV(4),
        .DEBOUNCE_TICKS(3),
        .AUTOFIRE_TICKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .joy1_raw_n(joy1_raw_n),
        .joy2_raw_n(joy2_raw_n),
        .autofire_en(autofire_en),
        .joy1(joy1),
        .joy2(joy2),
        .joy_changed(joy_changed)
    );

    always #5 clk = ~clk;

    // Scoreboard: every change pulse must match the next queued output pair.
    always @(negedge clk) begin
        if (!reset && joy_changed) begin
            logic [0:9] e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_pulse: joy1=%b joy2=%b with nothing expected", joy1, joy2);
            end else begin
                e = exp_q.pop_front();
                if ({joy1, joy2} !== e) begin
                    fails++;
                    $display("[TB] FAIL pulse_value: got %b_%b expected %b_%b", joy1, joy2, e[0:4], e[5:9]);
                end
            end
        end
    end

    task automatic wait_drain(input int budget, output int left);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        left = exp_q.size();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({joy1, joy2, joy_changed} !== 11'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: got %b_%b_%b expected all zero", joy1, joy2, joy_changed);
        end
        repeat (30) @(negedge clk);
        checks++;
        if ({joy1, joy2} !== 10'b0) begin
            fails++;
            $display("[TB] FAIL idle_outputs: got %b_%b expected 00000_00000", joy1, joy2);
        end
        checks++;
        if (pulses !== 0) begin
            fails++;
            $display("[TB] FAIL idle_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_debounce();
        int cyc;
        int left;
        int p0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        p0 = pulses;
        joy1_raw_n[1] = 1'b0;
        exp_q.push_back({5'b01000, 5'b00000});
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            cyc = i;
            if (joy1 === 5'b01000) break;
        end
        checks++;
        if (joy1 !== 5'b01000 || cyc > 15) begin
            fails++;
            $display("[TB] FAIL left_latency: joy1=%b after %0d clks, expected 01000 within 15", joy1, cyc);
        end
        wait_drain(5, left);
        checks++;
        if (left !== 0) begin
            fails++;
            $display("[TB] FAIL left_pulse_timeout: %0d expected pulses missing", left);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (pulses - p0 !== 1) begin
            fails++;
            $display("[TB] FAIL left_pulse_count: got %0d expected 1", pulses - p0);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulses;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            joy2_raw_n[4] = 1'b0;
            repeat (8) @(negedge clk);
            joy2_raw_n[4] = 1'b1;
            repeat (20) @(negedge clk);
            checks++;
            if ({joy1, joy2} !== {5'b01000, 5'b00000}) begin
                fails++;
                $display("[TB] FAIL glitch_%0d: got %b_%b expected 01000_00000", g, joy1, joy2);
            end
        end
        checks++;
        if (pulses - p0 !== 0) begin
            fails++;
            $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulses - p0);
        end
    endtask

    task automatic test_opposing();
        int left;
        joy1_raw_n[2] = 1'b0;
        exp_q.push_back({5'b00000, 5'b00000});
        wait_drain(25, left);
        checks++;
        if (left !== 0 || joy1 !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL left_right_cancel: joy1=%b missing=%0d expected 00000", joy1, left);
        end
        joy1_raw_n[2] = 1'b1;
        exp_q.push_back({5'b01000, 5'b00000});
        wait_drain(25, left);
        checks++;
        if (left !== 0 || joy1 !== 5'b01000) begin
            fails++;
            $display("[TB] FAIL right_release: joy1=%b missing=%0d expected 01000", joy1, left);
        end
        joy1_raw_n[3] = 1'b0;
        joy1_raw_n[4] = 1'b0;
        wait_drain(1, left);
        repeat (25) @(negedge clk);
        checks++;
        if (joy1 !== 5'b01000) begin
            fails++;
            $display("[TB] FAIL up_down_cancel: joy1=%b expected 01000", joy1);
        end
        joy1_raw_n = 5'b11111;
        exp_q.push_back({5'b00000, 5'b00000});
        wait_drain(25, left);
        checks++;
        if (left !== 0 || joy1 !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL release_all: joy1=%b missing=%0d expected 00000", joy1, left);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int left;
        @(negedge clk);
        joy1_raw_n[3] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({joy1, joy2} !== 10'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset_state: got %b_%b expected 00000_00000", joy1, joy2);
        end
        exp_q.push_back({5'b00010, 5'b00000});
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (joy1 !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL mid_reset_early: joy1=%b after 12 clks expected 00000", joy1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (joy1 !== 5'b00010) begin
            fails++;
            $display("[TB] FAIL mid_reset_full: joy1=%b after 13 clks expected 00010", joy1);
        end
        wait_drain(5, left);
        checks++;
        if (left !== 0) begin
            fails++;
            $display("[TB] FAIL mid_reset_pulse: %0d expected pulses missing", left);
        end
        joy1_raw_n[3] = 1'b1;
        exp_q.push_back({5'b00000, 5'b00000});
        wait_drain(25, left);
    endtask

    task automatic test_autofire();
        int left;
        int bad;
        @(negedge clk);
        autofire_en = 2'b10;
        joy1_raw_n[0] = 1'b0;
`ifdef JOY_AUTOFIRE_EN
        exp_q.push_back({5'b10000, 5'b00000});
        exp_q.push_back({5'b00000, 5'b00000});
        exp_q.push_back({5'b10000, 5'b00000});
        exp_q.push_back({5'b00000, 5'b00000});
        wait_drain(60, left);
        checks++;
        if (left !== 0) begin
            fails++;
            $display("[TB] FAIL autofire_toggle: %0d expected edges missing", left);
        end
        autofire_en = 2'b00;
        exp_q.push_back({5'b10000, 5'b00000});
        wait_drain(10, left);
        checks++;
        if (left !== 0 || joy1 !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL autofire_off: joy1=%b missing=%0d expected 10000", joy1, left);
        end
`else
        exp_q.push_back({5'b10000, 5'b00000});
        wait_drain(25, left);
        checks++;
        if (left !== 0) begin
            fails++;
            $display("[TB] FAIL fire_press: %0d expected pulses missing", left);
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (joy1 !== 5'b10000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("[TB] FAIL fire_steady: %0d cycles not 10000, expected 0", bad);
        end
        autofire_en = 2'b00;
`endif
        joy1_raw_n[0] = 1'b1;
        exp_q.push_back({5'b00000, 5'b00000});
        wait_drain(25, left);
        checks++;
        if (left !== 0 || joy1 !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL fire_release: joy1=%b missing=%0d expected 00000", joy1, left);
        end
    endtask

    task automatic test_back_to_back();
        int left;
        @(negedge clk);
        joy1_raw_n[2] = 1'b0;
        joy2_raw_n[0] = 1'b0;
        exp_q.push_back({5'b00100, 5'b10000});
        wait_drain(25, left);
        repeat (10) @(negedge clk);
        checks++;
        if (left !== 0 || {joy1, joy2} !== {5'b00100, 5'b10000}) begin
            fails++;
            $display("[TB] FAIL both_ports: got %b_%b missing=%0d expected 00100_10000", joy1, joy2, left);
        end
        joy1_raw_n = 5'b11111;
        joy2_raw_n = 5'b11111;
        exp_q.push_back({5'b00000, 5'b00000});
        wait_drain(25, left);
        checks++;
        if (left !== 0 || {joy1, joy2} !== 10'b0) begin
            fails++;
            $display("[TB] FAIL both_release: got %b_%b missing=%0d expected all zero", joy1, joy2, left);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_opposing();
        test_reset_mid_debounce();
        test_autofire();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
